// File: rtl/i2c_slave_pkg.sv
// i2c_slave_pkg: shared state encoding and constants for the I2C slave.
package i2c_slave_pkg;
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, INDEX, INDEX_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;
    localparam int         NUM_REGS     = 4;
    localparam logic [6:0] DEFAULT_ADDR = 7'h55;
    localparam logic       ACK          = 1'b0;
    localparam logic       NACK         = 1'b1;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: 2-flop synchronizer, optional majority spike filter, rise/fall detect.
// The filter is built when I2C_SLAVE_SPIKE_FILTER_EN is defined.
module i2c_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [1:0] sync;
    logic       prev;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync <= 2'b11;
        else sync <= {sync[0], raw};
`ifdef I2C_SLAVE_SPIKE_FILTER_EN
    logic [1:0] hist;
    logic       maj;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= 2'b11;
            maj  <= 1'b1;
        end else begin
            hist <= {hist[0], sync[1]};
            maj  <= (sync[1] & hist[0]) | (sync[1] & hist[1]) | (hist[0] & hist[1]);
        end
    end
    assign level = maj;
`else
    assign level = sync[1];
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) prev <= 1'b1;
        else prev <= level;
    assign rise = level & ~prev;
    assign fall = ~level & prev;
endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: oversampled I2C slave with a 4-entry register file and auto-increment pointer.
// Define I2C_SLAVE_SPIKE_FILTER_EN to add majority filtering on SCL/SDA.
module i2c_slave
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = DEFAULT_ADDR
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic SCL,
    inout  wire  SDA
);
    logic       scl, scl_rise, scl_fall, sda, sda_rise, sda_fall;
    logic       start, stop, sda_low;
    state_t     state;
    logic [3:0] cnt;
    logic [7:0] sh, bin;
    logic [1:0] ptr;
    logic [7:0] reg_00, reg_01, reg_02, reg_03;
    logic [7:0] rf [NUM_REGS];

    i2c_line_sync u_scl (.clk(CLK), .rst_n(RST_N), .raw(SCL), .level(scl), .rise(scl_rise), .fall(scl_fall));
    i2c_line_sync u_sda (.clk(CLK), .rst_n(RST_N), .raw(SDA), .level(sda), .rise(sda_rise), .fall(sda_fall));

    assign start = sda_fall & scl;
    assign stop  = sda_rise & scl;
    assign bin   = {sh[6:0], sda};
    assign SDA   = sda_low ? 1'b0 : 1'bz;
    always_comb rf = '{reg_00, reg_01, reg_02, reg_03};

    // ACK phases use cnt: 0 = waiting for the 8th fall, 1 = ACK driven until the 9th fall
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            cnt     <= '0;
            sh      <= '0;
            ptr     <= '0;
            sda_low <= 1'b0;
            reg_00  <= '0;
            reg_01  <= '0;
            reg_02  <= '0;
            reg_03  <= '0;
        end else if (stop) begin
            state   <= IDLE;
            sda_low <= 1'b0;
        end else if (start) begin
            state   <= ADDR;
            cnt     <= '0;
            sda_low <= 1'b0;
        end else begin
            case (state)
                ADDR, INDEX, WR_DATA: if (scl_rise) begin
                    sh  <= bin;
                    cnt <= (cnt == 4'd7) ? 4'd0 : cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        if (state == ADDR) state <= ADDR_ACK;
                        if (state == INDEX) begin
                            state <= INDEX_ACK;
                            ptr   <= bin[1:0];
                        end
                        if (state == WR_DATA) begin
                            state <= WR_ACK;
                            case (ptr)
                                2'd0: reg_00 <= bin;
                                2'd1: reg_01 <= bin;
                                2'd2: reg_02 <= bin;
                                2'd3: reg_03 <= bin;
                            endcase
                        end
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    if (cnt == 4'd0) begin
                        if (sh[7:1] == SLAVE_ADDR) begin
                            sda_low <= ~ACK;
                            cnt     <= 4'd1;
                        end else state <= IGNORE;
                    end else begin
                        cnt <= '0;
                        if (sh[0]) begin
                            state   <= RD_DATA;
                            sh      <= rf[ptr];
                            sda_low <= ~rf[ptr][7];
                        end else begin
                            state   <= INDEX;
                            sda_low <= 1'b0;
                        end
                    end
                end
                INDEX_ACK, WR_ACK: if (scl_fall) begin
                    sda_low <= (cnt == 4'd0) ? ~ACK : 1'b0;
                    cnt     <= (cnt == 4'd0) ? 4'd1 : 4'd0;
                    if (cnt != 4'd0) state <= WR_DATA;
                    if (cnt == 4'd0 && state == WR_ACK) ptr <= ptr + 2'd1;
                end
                RD_DATA: begin
                    if (scl_rise) cnt <= cnt + 4'd1;
                    if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            state   <= RD_ACK;
                            cnt     <= '0;
                            sda_low <= 1'b0;
                        end else begin
                            sh      <= {sh[6:0], 1'b0};
                            sda_low <= ~sh[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda == NACK) state <= IGNORE;
                        else cnt <= 4'd1;
                    end
                    if (scl_fall && cnt == 4'd1) begin
                        ptr     <= ptr + 2'd1;
                        sh      <= rf[ptr + 2'd1];
                        sda_low <= ~rf[ptr + 2'd1][7];
                        cnt     <= '0;
                        state   <= RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: directed and randomized I2C register traffic checked against a register-file model.
module tb_i2c_slave;
    logic       clk = 1'b0, rst_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
    wire        sda_bus;
    int         total = 0, fails = 0, mptr = 0;
    logic [7:0] mregs [4];
    logic [7:0] wbuf [4];

    always #5 clk = ~clk;
    assign sda_bus = sda_m ? 1'bz : 1'b0;
    pullup (sda_bus);

    i2c_slave dut (.CLK(clk), .RST_N(rst_n), .SCL(scl_m), .SDA(sda_bus));

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        check(tag, {7'd0, obs}, {7'd0, exp});
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_reg00"}, dut.reg_00, mregs[0]);
        check({tag, "_reg01"}, dut.reg_01, mregs[1]);
        check({tag, "_reg02"}, dut.reg_02, mregs[2]);
        check({tag, "_reg03"}, dut.reg_03, mregs[3]);
    endtask

    task automatic bus_start;
        sda_m = 1'b1; tick(4); scl_m = 1'b1; tick(8); sda_m = 1'b0; tick(8); scl_m = 1'b0; tick(4);
    endtask

    task automatic bus_stop;
        sda_m = 1'b0; tick(6); scl_m = 1'b1; tick(8); sda_m = 1'b1; tick(8);
    endtask

    task automatic bus_bit(input logic b, output logic r);
        sda_m = b; tick(6); scl_m = 1'b1; tick(5); r = sda_bus; tick(5); scl_m = 1'b0; tick(4);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
        bus_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, r);
            d[i] = r;
        end
        bus_bit(~mack, r);
    endtask

    task automatic write_txn(input logic [7:0] idx, input int n, input string tag);
        logic a;
        bus_start;
        wr_byte(8'hAA, a); chk1({tag, "_addr_ack"}, a, 1'b1);
        wr_byte(idx, a);   chk1({tag, "_idx_ack"}, a, 1'b1);
        mptr = int'(idx) % 4;
        for (int i = 0; i < n; i++) begin
            wr_byte(wbuf[i], a); chk1({tag, "_data_ack"}, a, 1'b1);
            mregs[mptr] = wbuf[i];
            mptr = (mptr + 1) % 4;
        end
        bus_stop;
        check_regs(tag);
    endtask

    task automatic read_txn(input logic [7:0] idx, input logic set_index, input int n, input string tag);
        logic       a;
        logic [7:0] d;
        if (set_index) begin
            bus_start;
            wr_byte(8'hAA, a); chk1({tag, "_waddr_ack"}, a, 1'b1);
            wr_byte(idx, a);   chk1({tag, "_idx_ack"}, a, 1'b1);
            mptr = int'(idx) % 4;
        end
        bus_start;
        wr_byte(8'hAB, a); chk1({tag, "_raddr_ack"}, a, 1'b1);
        for (int i = 0; i < n; i++) begin
            rd_byte(i < n - 1, d);
            check({tag, "_data"}, d, mregs[mptr]);
            if (i < n - 1) mptr = (mptr + 1) % 4;
        end
        chk1({tag, "_released"}, sda_bus, 1'b1);
        bus_stop;
    endtask

    initial begin
        logic a, r;
        for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
        tick(5);
        chk1("reset_sda", sda_bus, 1'b1);
        check("reset_ptr", {6'd0, dut.ptr}, 8'h00);
        check_regs("reset");
        rst_n = 1'b1;
        tick(10);

        wbuf[0] = 8'h5A;
        write_txn(8'h01, 1, "wr1");

        force dut.reg_01 = 8'h5A;
        mregs[1] = 8'h5A;
        read_txn(8'h01, 1'b1, 1, "rd1");
        release dut.reg_01;

        wbuf[0] = 8'h5A; wbuf[1] = 8'hA5;
        write_txn(8'h01, 2, "burst_wr");

        wbuf[0] = 8'hA5; wbuf[1] = 8'h5A; wbuf[2] = 8'hAA; wbuf[3] = 8'h55;
        write_txn(8'h00, 4, "fill");
        read_txn(8'h01, 1'b1, 2, "burst_rd");

        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        write_txn(8'h03, 2, "wrap");
        read_txn(8'h00, 1'b0, 1, "persist");

        bus_start;
        wr_byte(8'hA8, a); chk1("mismatch_addr_nack", a, 1'b0);
        wr_byte(8'h00, a); chk1("mismatch_idx_nack", a, 1'b0);
        wr_byte(8'hFF, a); chk1("mismatch_data_nack", a, 1'b0);
        bus_stop;
        check_regs("mismatch");

        for (int k = 0; k < 6; k++) begin
            int n;
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom_range(0, 255));
            write_txn(8'($urandom_range(0, 255)), n, "rand_wr");
            read_txn(8'($urandom_range(0, 255)), 1'b1, int'($urandom_range(1, 4)), "rand_rd");
        end

        wbuf[0] = 8'h00;
        write_txn(8'h02, 1, "rst_prep");
        bus_start;
        wr_byte(8'hAA, a); chk1("rst_waddr_ack", a, 1'b1);
        wr_byte(8'h02, a); chk1("rst_idx_ack", a, 1'b1);
        bus_start;
        wr_byte(8'hAB, a); chk1("rst_raddr_ack", a, 1'b1);
        for (int i = 0; i < 3; i++) bus_bit(1'b1, r);
        sda_m = 1'b1; tick(6); scl_m = 1'b1; tick(5);
        chk1("rst_slave_driving", sda_bus, 1'b0);
        rst_n = 1'b0;
        #1;
        chk1("rst_sda_released", sda_bus, 1'b1);
        tick(5);
        for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
        mptr = 0;
        check_regs("rst_mid");
        check("rst_mid_ptr", {6'd0, dut.ptr}, 8'h00);
        rst_n = 1'b1;
        tick(10);
        for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom_range(0, 255));
        write_txn(8'($urandom_range(0, 255)), 3, "post_rst_wr");
        read_txn(8'($urandom_range(0, 255)), 1'b1, 4, "post_rst_rd");

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
